// File: rtl/esc_pkg.sv
// Shared state encodings and reference-width constants for the ESC sequencer.
// signed_ref converts an unsigned magnitude plus sign flag into the ESC reference.
package esc_pkg;

    localparam int MAG_W = 7;
    localparam int REF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_RAMP  = 3'd2,
        ST_RUN   = 3'd3,
        ST_BRAKE = 3'd4,
        ST_FAULT = 3'd5
    } esc_state_t;

    function automatic logic signed [REF_W-1:0] signed_ref(input logic [MAG_W-1:0] mag,
                                                           input logic neg);
        logic signed [REF_W-1:0] ext;
        ext = signed'({1'b0, mag});
        return neg ? -ext : ext;
    endfunction

endpackage

// File: rtl/esc_stall_wdt.sv
// Saturating stall watchdog: counts enabled cycles since the last clear
// and flags timeout once LIMIT cycles have elapsed.
module esc_stall_wdt #(
    parameter int LIMIT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(LIMIT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_timeout = (r_count == CW'(LIMIT));

endmodule

// File: rtl/esc_sequencer.sv
// ESC start/ramp/run/brake sequencer with stall fault, driving a signed speed
// reference and drive enable; every output is registered from next-state values.
module esc_sequencer
    import esc_pkg::*;
#(
    parameter int RAMP_STEP    = 4,
    parameter int ALIGN_TICKS  = 8,
    parameter int ALIGN_MAG    = 10,
    parameter int STALL_CYCLES = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    dir,
    input  logic [MAG_W-1:0]        target_mag,
    input  logic                    tick,
    input  logic                    encoder_edge,
    input  logic                    fault_clear,
    output logic                    pwm_en,
    output logic signed [REF_W-1:0] period_ref,
    output logic [2:0]              state,
    output logic                    fault
);

    localparam int ACW = $clog2(ALIGN_TICKS + 1);
    localparam logic [MAG_W-1:0] STEP  = MAG_W'(RAMP_STEP);
    localparam logic [MAG_W-1:0] A_MAG = MAG_W'(ALIGN_MAG);

    esc_state_t              r_state, w_state_next;
    logic [MAG_W-1:0]        r_mag, w_mag_next;
    logic [MAG_W-1:0]        r_target, w_target_next;
    logic                    r_dir, w_dir_next;
    logic                    r_dir_pend, w_dir_pend_next;
    logic                    r_zero_first, w_zero_first_next;
    logic [ACW-1:0]          r_align_cnt, w_align_cnt_next;
    logic                    r_pwm_en, w_pwm_en_next;
    logic signed [REF_W-1:0] r_period_ref, w_period_ref_next;
    logic                    r_fault, w_fault_next;

    logic             w_timeout;
    logic             w_wdt_clear;
    logic             w_wdt_enable;
    logic [MAG_W-1:0] w_mag_dec;
    logic [MAG_W-1:0] w_mag_toward;
    logic             w_start_ok;

    assign w_start_ok = start && !stop && (target_mag != '0);
    assign w_mag_dec  = (r_mag > STEP) ? (r_mag - STEP) : '0;

    // Step toward the target, clamping on the final step so it never overshoots.
    always_comb begin
        w_mag_toward = r_mag;
        if (r_mag < r_target) begin
            w_mag_toward = ((r_target - r_mag) > STEP) ? (r_mag + STEP) : r_target;
        end else if (r_mag > r_target) begin
            w_mag_toward = ((r_mag - r_target) > STEP) ? (r_mag - STEP) : r_target;
        end
    end

    assign w_wdt_enable = (r_state == ST_RAMP) || (r_state == ST_RUN);
    assign w_wdt_clear  = encoder_edge || ((w_state_next == ST_RAMP) && (r_state != ST_RAMP));

    esc_stall_wdt #(
        .LIMIT(STALL_CYCLES)
    ) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wdt_clear),
        .i_enable (w_wdt_enable),
        .o_timeout(w_timeout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_mag        <= '0;
            r_target     <= '0;
            r_dir        <= 1'b0;
            r_dir_pend   <= 1'b0;
            r_zero_first <= 1'b0;
            r_align_cnt  <= '0;
            r_pwm_en     <= 1'b0;
            r_period_ref <= '0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_mag        <= w_mag_next;
            r_target     <= w_target_next;
            r_dir        <= w_dir_next;
            r_dir_pend   <= w_dir_pend_next;
            r_zero_first <= w_zero_first_next;
            r_align_cnt  <= w_align_cnt_next;
            r_pwm_en     <= w_pwm_en_next;
            r_period_ref <= w_period_ref_next;
            r_fault      <= w_fault_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_mag_next        = r_mag;
        w_target_next     = r_target;
        w_dir_next        = r_dir;
        w_dir_pend_next   = r_dir_pend;
        w_zero_first_next = r_zero_first;
        w_align_cnt_next  = r_align_cnt;
        case (r_state)
            ST_IDLE: begin
                w_mag_next = '0;
                if (w_start_ok) begin
                    w_state_next      = ST_ALIGN;
                    w_target_next     = target_mag;
                    w_dir_next        = dir;
                    w_dir_pend_next   = dir;
                    w_mag_next        = A_MAG;
                    w_align_cnt_next  = '0;
                    w_zero_first_next = 1'b0;
                end
            end
            ST_ALIGN: begin
                w_mag_next = A_MAG;
                if (stop) begin
                    w_state_next = ST_BRAKE;
                end else if (tick) begin
                    if (r_align_cnt == ACW'(ALIGN_TICKS - 1)) begin
                        w_state_next     = ST_RAMP;
                        w_align_cnt_next = '0;
                    end else begin
                        w_align_cnt_next = r_align_cnt + 1'b1;
                    end
                end
            end
            ST_RAMP: begin
                if (w_timeout) begin
                    w_state_next = ST_FAULT;
                    w_mag_next   = '0;
                end else if (stop) begin
                    w_state_next      = ST_BRAKE;
                    w_zero_first_next = 1'b0;
                end else if (!r_zero_first && (r_mag == r_target)) begin
                    w_state_next = ST_RUN;
                end else if (tick) begin
                    // A reversal runs down through zero before the sign flips.
                    if (r_zero_first) begin
                        w_mag_next = w_mag_dec;
                        if (w_mag_dec == '0) begin
                            w_dir_next        = r_dir_pend;
                            w_zero_first_next = 1'b0;
                        end
                    end else begin
                        w_mag_next = w_mag_toward;
                    end
                end
            end
            ST_RUN: begin
                if (w_timeout) begin
                    w_state_next = ST_FAULT;
                    w_mag_next   = '0;
                end else if (stop) begin
                    w_state_next = ST_BRAKE;
                end else if (w_start_ok) begin
                    w_state_next      = ST_RAMP;
                    w_target_next     = target_mag;
                    w_dir_pend_next   = dir;
                    w_zero_first_next = (dir != r_dir);
                end
            end
            ST_BRAKE: begin
                if (r_mag == '0) begin
                    w_state_next = ST_IDLE;
                end else if (tick) begin
                    w_mag_next = w_mag_dec;
                end
            end
            ST_FAULT: begin
                w_mag_next = '0;
                if (fault_clear) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_mag_next   = '0;
            end
        endcase
    end

    always_comb begin
        w_pwm_en_next     = (w_state_next == ST_ALIGN) || (w_state_next == ST_RAMP) ||
                            (w_state_next == ST_RUN)   || (w_state_next == ST_BRAKE);
        w_period_ref_next = signed_ref(w_mag_next, w_dir_next);
        w_fault_next      = (w_state_next == ST_FAULT);
    end

    assign state      = r_state;
    assign pwm_en     = r_pwm_en;
    assign period_ref = r_period_ref;
    assign fault      = r_fault;

endmodule

// File: tb/tb_esc_sequencer.sv
// Directed bench for esc_sequencer: align/ramp/run, brake, reversal, stall fault,
// start/stop arbitration and asynchronous reset, with hand-computed expectations.
module tb_esc_sequencer;

    localparam int STALL = 300;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              dir = 1'b0;
    logic [6:0]        target_mag = '0;
    logic              tick = 1'b0;
    logic              encoder_edge = 1'b0;
    logic              fault_clear = 1'b0;
    logic              pwm_en;
    logic signed [7:0] period_ref;
    logic [2:0]        state;
    logic              fault;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  edge_en = 1'b1;

    esc_sequencer #(
        .RAMP_STEP(4),
        .ALIGN_TICKS(8),
        .ALIGN_MAG(10),
        .STALL_CYCLES(STALL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .dir         (dir),
        .target_mag  (target_mag),
        .tick        (tick),
        .encoder_edge(encoder_edge),
        .fault_clear (fault_clear),
        .pwm_en      (pwm_en),
        .period_ref  (period_ref),
        .state       (state),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Encoder edge every 100 clk while enabled.
    initial begin
        forever begin
            repeat (99) @(negedge clk);
            if (edge_en) begin
                encoder_edge = 1'b1;
                @(negedge clk);
                encoder_edge = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_val);
        end else begin
            $display("ok   %s = %0d", tag, obs);
        end
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse tick for one clk; returns at the negedge where its effect is visible.
    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_start(input int mag, input bit d, input bit with_stop);
        @(negedge clk);
        start = 1'b1;
        target_mag = 7'(mag);
        dir = d;
        stop = with_stop;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Start from IDLE and tick until RUN, bounded to 40 ramp ticks.
    task automatic go_run(input int mag, input bit d);
        do_start(mag, d, 1'b0);
        for (int k = 0; k < 8; k++) begin
            do_tick();
            gap(8);
        end
        for (int k = 0; k < 40; k++) begin
            if (state == 3'd3) break;
            do_tick();
            gap(8);
        end
        check_eq("reach_run", int'(state), 3);
    endtask

    initial begin
        int exp_ref;
        bit got_fault;

        gap(3);
        check_eq("rst_state", int'(state), 0);
        check_eq("rst_pwm", int'(pwm_en), 0);
        check_eq("rst_ref", int'(period_ref), 0);
        check_eq("rst_fault", int'(fault), 0);
        @(negedge clk);
        reset = 1'b0;
        gap(2);

        // Align then ramp to +40
        do_start(40, 1'b0, 1'b0);
        check_eq("align_state", int'(state), 1);
        check_eq("align_ref", int'(period_ref), 10);
        check_eq("align_pwm", int'(pwm_en), 1);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            check_eq($sformatf("align_tick%0d_state", k), int'(state), (k == 8) ? 2 : 1);
            check_eq($sformatf("align_tick%0d_ref", k), int'(period_ref), 10);
            gap(8);
        end
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            exp_ref = (10 + 4 * k > 40) ? 40 : 10 + 4 * k;
            check_eq($sformatf("ramp_tick%0d_ref", k), int'(period_ref), exp_ref);
            gap(8);
        end
        check_eq("run_state", int'(state), 3);
        check_eq("run_ref", int'(period_ref), 40);

        // Brake from +40
        do_stop();
        check_eq("brake_state", int'(state), 4);
        check_eq("brake_ref0", int'(period_ref), 40);
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            check_eq($sformatf("brake_tick%0d_ref", k), int'(period_ref), 40 - 4 * k);
            gap(8);
        end
        check_eq("brake_end_state", int'(state), 0);
        check_eq("brake_end_pwm", int'(pwm_en), 0);

        // Reversal from +40 to -22
        go_run(40, 1'b0);
        check_eq("rev_pre_ref", int'(period_ref), 40);
        do_start(22, 1'b1, 1'b0);
        check_eq("rev_state", int'(state), 2);
        check_eq("rev_ref0", int'(period_ref), 40);
        for (int k = 1; k <= 16; k++) begin
            do_tick();
            if (k <= 10) exp_ref = 40 - 4 * k;
            else exp_ref = -((4 * (k - 10) > 22) ? 22 : 4 * (k - 10));
            check_eq($sformatf("rev_tick%0d_ref", k), int'(period_ref), exp_ref);
            gap(8);
        end
        check_eq("rev_run_state", int'(state), 3);
        check_eq("rev_run_ref", int'(period_ref), -22);

        // Stall: withhold encoder edges
        edge_en = 1'b0;
        got_fault = 1'b0;
        for (int c = 0; c < 2 * STALL; c++) begin
            @(negedge clk);
            if (state == 3'd5) begin
                got_fault = 1'b1;
                break;
            end
        end
        check_eq("stall_seen", int'(got_fault), 1);
        check_eq("stall_state", int'(state), 5);
        check_eq("stall_pwm", int'(pwm_en), 0);
        check_eq("stall_fault", int'(fault), 1);
        check_eq("stall_ref", int'(period_ref), 0);
        do_stop();
        check_eq("fault_stop_ignored", int'(state), 5);
        do_start(30, 1'b0, 1'b0);
        check_eq("fault_start_ignored", int'(state), 5);
        @(negedge clk);
        fault_clear = 1'b1;
        @(negedge clk);
        fault_clear = 1'b0;
        check_eq("clear_state", int'(state), 0);
        check_eq("clear_fault", int'(fault), 0);
        edge_en = 1'b1;

        // Start/stop arbitration and zero target in IDLE
        do_start(40, 1'b0, 1'b1);
        check_eq("start_stop_state", int'(state), 0);
        check_eq("start_stop_pwm", int'(pwm_en), 0);
        do_start(0, 1'b0, 1'b0);
        check_eq("zero_tgt_state", int'(state), 0);

        // Stop during ALIGN brakes down from the align magnitude
        do_start(50, 1'b1, 1'b0);
        check_eq("align_neg_ref", int'(period_ref), -10);
        do_stop();
        check_eq("align_stop_state", int'(state), 4);
        for (int k = 1; k <= 3; k++) begin
            do_tick();
            exp_ref = (10 - 4 * k < 0) ? 0 : -(10 - 4 * k);
            check_eq($sformatf("align_brake%0d_ref", k), int'(period_ref), exp_ref);
            gap(8);
        end
        check_eq("align_brake_idle", int'(state), 0);

        // Asynchronous reset mid-RAMP
        do_start(40, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            do_tick();
            gap(8);
        end
        check_eq("pre_rst_state", int'(state), 2);
        check_eq("pre_rst_ref", int'(period_ref), 18);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("async_rst_pwm", int'(pwm_en), 0);
        check_eq("async_rst_ref", int'(period_ref), 0);
        check_eq("async_rst_state", int'(state), 0);
        @(negedge clk);
        reset = 1'b0;
        gap(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/esc_sequencer.md
ESC_SEQUENCER -- requirements
Module: esc_sequencer

Interface
REQ-001 Parameter: RAMP_STEP, 4, magnitude increment/decrement per ramp tick.
REQ-002 Parameter: ALIGN_TICKS, 8, ticks spent in ALIGN.
REQ-003 Parameter: ALIGN_MAG, 10, period_ref magnitude during ALIGN.
REQ-004 Parameter: STALL_CYCLES, 50000, clk cycles without encoder_edge before stall fault.
REQ-005 Port: clk  in  1  clock, rising edge.
REQ-006 Port: reset  in  1  reset, asynchronous, active-high.
REQ-007 Port: start  in  1  single-cycle start/retarget request.
REQ-008 Port: stop  in  1  single-cycle controlled-stop request.
REQ-009 Port: dir  in  1  requested direction, 0 positive, 1 negative; sampled with start.
REQ-010 Port: target_mag  in  7  requested speed-reference magnitude, 1..127; sampled with start.
REQ-011 Port: tick  in  1  ramp time-base strobe, one clk wide.
REQ-012 Port: encoder_edge  in  1  one-clk pulse per encoder A rising edge.
REQ-013 Port: fault_clear  in  1  single-cycle fault acknowledge.
REQ-014 Port: pwm_en  out  1  ESC drive enable, active-high.
REQ-015 Port: period_ref  out  8  signed two's-complement speed reference to ESC.
REQ-016 Port: state  out  3  current state encoding.
REQ-017 Port: fault  out  1  stall fault latched.

Function
REQ-018 States SHALL be IDLE=0, ALIGN=1, RAMP=2, RUN=3, BRAKE=4, FAULT=5; all outputs registered, visible the cycle after the causing input is sampled.
REQ-019 period_ref SHALL equal +mag when latched dir=0, -mag when dir=1; mag is a 7-bit unsigned internal register.
REQ-020 IDLE: pwm_en=0, mag=0; start with target_mag!=0 latches target/dir -> ALIGN; start with target_mag=0 ignored.
REQ-021 ALIGN: pwm_en=1, mag=ALIGN_MAG; after ALIGN_TICKS ticks -> RAMP.
REQ-022 RAMP: each tick mag moves RAMP_STEP toward latched target, clamped to target (no overshoot, no wrap); cycle mag==target -> RUN.
REQ-023 RUN: mag held; start with nonzero target_mag re-latches target/dir and -> RAMP; if dir differs, mag first ramps to 0 then toward new target with new sign.
REQ-024 stop in ALIGN, RAMP or RUN -> BRAKE; BRAKE decrements mag by RAMP_STEP per tick, floor 0; cycle mag==0 -> IDLE with pwm_en=0.
REQ-025 start during BRAKE or FAULT SHALL be ignored; start and stop same cycle: stop wins.
REQ-026 Stall watchdog: counter cleared by encoder_edge and on entry to RAMP; increments every clk in RAMP/RUN, saturates at STALL_CYCLES; reaching it -> FAULT.
REQ-027 FAULT: pwm_en=0, mag=0, fault=1 in the same registered update; fault_clear -> IDLE, fault=0; stop in FAULT has no effect.
REQ-028 tick and encoder_edge in same cycle as a transition SHALL act only in the new state from the next cycle.

Reset
REQ-029 reset SHALL force state=IDLE, pwm_en=0, period_ref=0, fault=0, all counters and latched target/dir to 0 immediately.
REQ-030 reset asserted mid-RAMP/RUN SHALL drop pwm_en within the same cycle as assertion (asynchronous).

Structure
REQ-031 State encodings and the signed-magnitude helper width constants SHALL live in shared package esc_pkg.
REQ-032 Stall watchdog SHALL be a sub-module esc_stall_wdt (clear, enable, saturating count, timeout flag).

Verification
REQ-033 start, target_mag=40, dir=0, tick every 10 clk, edges every 100 clk -> ALIGN for 8 ticks at +10, RAMP +4/tick, RUN at period_ref=+40.
REQ-034 RUN at +40, stop -> BRAKE 40,36,...,0 per tick, then IDLE, pwm_en=0.
REQ-035 RUN at +40, start target_mag=22 dir=1 -> ramp to 0 then -4..-20,-22 (clamped), RUN at -22.
REQ-036 RUN, encoder_edge withheld STALL_CYCLES clk -> FAULT, pwm_en=0, fault=1; fault_clear -> IDLE.
REQ-037 start and stop same cycle in IDLE -> stays IDLE; start with target_mag=0 -> stays IDLE.
REQ-038 reset asserted mid-RAMP -> pwm_en=0, period_ref=0, state=IDLE before next clk edge.
